// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common keyboard command
// bytes and the odd-parity frame builder.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RQST,
      SEND,
      ACK,
      WAIT_IDLE
   } tx_state_e;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ECHO    = 8'hEE;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] RSP_ACK     = 8'hFA;

   localparam int FRAME_BITS = 10;

   // Transmit order is LSB first: 8 data bits, odd parity, then the stop bit.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester (master) and the PS/2 host
// transmitter (slave).
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;
   logic       busy;

   modport master (output tx_valid, tx_data, input tx_ready, tx_done, tx_err, busy);
   modport slave  (input tx_valid, tx_data, output tx_ready, tx_done, tx_err, busy);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one asynchronous PS/2 line, plus a one-cycle
// falling-edge strobe derived from the synchronized value.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic sync,
   output logic fe
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = line_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours; blocking here would collapse the chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync = sync_q;
   assign fe   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain enables.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 12000,
   parameter int TIMEOUT_CYCLES = 1500000
) (
   input  logic           clk,
   input  logic           rst,
   ps2_host_tx_if.slave   host,
   input  logic           ps2_clk_in,
   input  logic           ps2_data_in,
   output logic           ps2_clk_oe,
   output logic           ps2_data_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

   tx_state_e             state_q, state_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [INH_W-1:0]      inh_cnt_q, inh_cnt_d;
   logic                  clk_oe_q, clk_oe_d;
   logic                  data_oe_q, data_oe_d;
   logic                  ack_q, ack_d;

   logic sync_clk, clk_fe, sync_data, unused_data_fe;
   logic lines_idle, ready, done_pulse, err_pulse, timeout_hit;

   ps2_line_sync u_clk_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_clk_in),
      .sync    (sync_clk),
      .fe      (clk_fe)
   );

   ps2_line_sync u_data_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_data_in),
      .sync    (sync_data),
      .fe      (unused_data_fe)
   );

   assign lines_idle = sync_clk & sync_data;
   assign ready      = (state_q == IDLE) & lines_idle;

`ifdef PS2_TX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   // Free-running from the moment INHIBIT ends; device edges never restart it.
   always_comb begin
      wd_d = wd_q + 1'b1;
      if (state_q == IDLE || state_q == INHIBIT) wd_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end

   assign timeout_hit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1))
                      & (state_q != IDLE) & (state_q != INHIBIT)
                      & ~((state_q == WAIT_IDLE) & lines_idle);
`else
   // Never true; the parameter stays referenced so both builds share one interface.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      bit_cnt_d  = bit_cnt_q;
      inh_cnt_d  = inh_cnt_q;
      clk_oe_d   = clk_oe_q;
      data_oe_d  = data_oe_q;
      ack_d      = ack_q;
      done_pulse = 1'b0;
      err_pulse  = 1'b0;

      unique case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (host.tx_valid && ready) begin
               frame_d   = build_frame(host.tx_data);
               inh_cnt_d = '0;
               bit_cnt_d = '0;
               clk_oe_d  = 1'b1;
               state_d   = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               data_oe_d = 1'b1;
               state_d   = RQST;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         RQST: begin
            clk_oe_d = 1'b0;
            state_d  = SEND;
         end
         SEND: begin
            if (clk_fe) begin
               data_oe_d = ~frame_q[bit_cnt_q];
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 4'(FRAME_BITS - 1)) state_d = ACK;
            end
         end
         ACK: begin
            if (clk_fe) begin
               ack_d   = ~sync_data;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (lines_idle) begin
               done_pulse = ack_q;
               err_pulse  = ~ack_q;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout_hit) begin
         clk_oe_d   = 1'b0;
         data_oe_d  = 1'b0;
         done_pulse = 1'b0;
         err_pulse  = 1'b1;
         state_d    = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         bit_cnt_q <= '0;
         inh_cnt_q <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_cnt_q <= bit_cnt_d;
         inh_cnt_q <= inh_cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         ack_q     <= ack_d;
      end
   end

   // Gating with timeout_hit releases the pads in the expiry cycle itself.
   assign ps2_clk_oe    = clk_oe_q & ~timeout_hit;
   assign ps2_data_oe   = data_oe_q & ~timeout_hit;
   assign host.tx_ready = ready;
   assign host.tx_done  = done_pulse;
   assign host.tx_err   = err_pulse;
   assign host.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx against an open-drain PS/2 device model.
// Shortened inhibit/timeout parameters keep the run small.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 20;
   localparam int TO  = 1000;
   localparam int HP  = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;
   logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0, err_cnt = 0, busy_rises = 0, rdy_busy = 0;
   logic busy_prev = 1'b0;

   ps2_host_tx_if host_if ();

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .host        (host_if),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   always @(negedge clk) begin
      busy_prev <= host_if.busy;
      if (host_if.tx_done)                   done_cnt   <= done_cnt + 1;
      if (host_if.tx_err)                    err_cnt    <= err_cnt + 1;
      if (host_if.busy && !busy_prev)        busy_rises <= busy_rises + 1;
      if (host_if.busy && host_if.tx_ready)  rdy_busy   <= rdy_busy + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic request(input logic [7:0] d);
      @(negedge clk);
      host_if.tx_data  = d;
      host_if.tx_valid = 1'b1;
      @(negedge clk);
      host_if.tx_valid = 1'b0;
   endtask

   task automatic dev_wait_send(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
         if (ps2_clk_in === 1'b1 && ps2_data_in === 1'b0 && host_if.busy === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
   endtask

   // rx[0] start, rx[8:1] data, rx[9] parity, rx[10] stop, each read just before the next fall.
   task automatic dev_frame(input bit ack, output logic [10:0] rx, output bit ok);
      rx = '0;
      dev_wait_send(ok);
      if (ok) begin
         tick(HP);
         rx[0] = ps2_data_in;
         for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            tick(HP);
            dev_clk_low = 1'b0;
            tick(HP);
            rx[k] = ps2_data_in;
         end
         dev_data_low = ack;
         dev_clk_low  = 1'b1;
         tick(HP);
         dev_clk_low  = 1'b0;
         tick(HP);
         dev_data_low = 1'b0;
      end
   endtask

   task automatic wait_not_busy(input string tag);
      int c;
      c = 0;
      while (host_if.busy !== 1'b0 && c < 400) begin
         @(negedge clk);
         c++;
      end
      check(tag, host_if.busy, 1'b0);
   endtask

   initial begin
      logic [10:0] rx;
      bit          ok;
      int          d0, e0, b0, r0, hi, drise, cfall, c;

      host_if.tx_valid = 1'b0;
      host_if.tx_data  = 8'h00;

      // Reset state
      tick(3);
      check("reset_outputs", {host_if.tx_ready, host_if.busy, host_if.tx_done,
                              host_if.tx_err, ps2_clk_oe, ps2_data_oe}, 6'b0);
      rst = 1'b0;
      tick(4);
      check("ready_after_reset", host_if.tx_ready, 1'b1);

      // 0xED with ACK, plus inhibit timing
      d0 = done_cnt; e0 = err_cnt;
      host_if.tx_data  = CMD_SET_LED;
      host_if.tx_valid = 1'b1;
      hi = 0; drise = -1; cfall = -1;
      fork
         dev_frame(1'b1, rx, ok);
         begin
            @(negedge clk);
            host_if.tx_valid = 1'b0;
            for (int i = 1; i <= 100 && cfall < 0; i++) begin
               if (ps2_data_oe && drise < 0) drise = i;
               if (ps2_clk_oe) hi++;
               else cfall = i;
               @(negedge clk);
            end
         end
      join
      check("ed_inhibit_len", hi, INH + 1);
      check("ed_data_lead", cfall - drise, 1);
      check("ed_frame_seen", ok, 1'b1);
      check("ed_start", rx[0], 1'b0);
      check("ed_data", rx[8:1], 8'hED);
      check("ed_parity", rx[9], 1'b1);
      check("ed_stop", rx[10], 1'b1);
      wait_not_busy("ed_busy_drop");
      tick(2);
      check("ed_done_once", done_cnt - d0, 1);
      check("ed_no_err", err_cnt - e0, 0);
      check("ed_ready_again", host_if.tx_ready, 1'b1);

      // 0xF3 with NACK
      d0 = done_cnt; e0 = err_cnt;
      request(8'hF3);
      dev_frame(1'b0, rx, ok);
      check("nack_frame", {ok, rx}, {1'b1, 1'b1, 1'b1, 8'hF3, 1'b0});
      wait_not_busy("nack_busy_drop");
      tick(2);
      check("nack_err_once", err_cnt - e0, 1);
      check("nack_no_done", done_cnt - d0, 0);

      // 0x00 with tx_valid held and tx_data changed mid-frame
      d0 = done_cnt; b0 = busy_rises; r0 = rdy_busy;
      @(negedge clk);
      host_if.tx_data  = 8'h00;
      host_if.tx_valid = 1'b1;
      fork
         dev_frame(1'b1, rx, ok);
         begin
            tick(120);
            host_if.tx_data = 8'hFF;
         end
      join
      c = 0;
      while (host_if.tx_done !== 1'b1 && c < 300) begin
         @(negedge clk);
         c++;
      end
      check("hold_done_seen", host_if.tx_done, 1'b1);
      check("hold_ready_in_pulse", host_if.tx_ready, 1'b0);
      host_if.tx_valid = 1'b0;
      tick(10);
      check("hold_data", rx[8:1], 8'h00);
      check("hold_parity", rx[9], 1'b1);
      check("hold_one_transfer", busy_rises - b0, 1);
      check("hold_ready_while_busy", rdy_busy - r0, 0);
      check("hold_done_once", done_cnt - d0, 1);
      check("hold_idle", host_if.busy, 1'b0);

      // Reset after the fourth falling edge
      d0 = done_cnt; e0 = err_cnt;
      request(8'hF0);
      dev_wait_send(ok);
      check("rst_send_reached", ok, 1'b1);
      tick(HP);
      for (int k = 1; k <= 4; k++) begin
         dev_clk_low = 1'b1;
         tick(HP);
         if (k < 4) begin
            dev_clk_low = 1'b0;
            tick(HP);
         end
      end
      check("rst_pre_state", {host_if.busy, ps2_data_oe}, 2'b11);
      rst = 1'b1;
      #1;
      check("rst_immediate", {host_if.busy, host_if.tx_done, host_if.tx_err,
                              ps2_clk_oe, ps2_data_oe}, 5'b0);
      @(negedge clk);
      dev_clk_low = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(5);
      check("rst_no_pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);
      check("rst_ready", host_if.tx_ready, 1'b1);
      request(CMD_ECHO);
      dev_frame(1'b1, rx, ok);
      check("ee_frame", {ok, rx}, {1'b1, 1'b1, 1'b1, 8'hEE, 1'b0});
      wait_not_busy("ee_busy_drop");
      tick(2);
      check("ee_done_once", done_cnt - d0, 1);

      // Silent device
      e0 = err_cnt;
      request(CMD_RESET);
`ifdef PS2_TX_TIMEOUT_EN
      c = 0;
      while (host_if.tx_err !== 1'b1 && c < 3 * TO) begin
         @(negedge clk);
         c++;
      end
      check("to_err_seen", host_if.tx_err, 1'b1);
      check("to_lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      tick(3);
      check("to_err_once", err_cnt - e0, 1);
      check("to_idle", host_if.busy, 1'b0);
`else
      c = 0;
      repeat (2 * TO) begin
         @(negedge clk);
         if (!host_if.busy) c++;
      end
      check("silent_busy_held", c, 0);
      check("silent_no_err", err_cnt - e0, 0);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(4);
      check("silent_reset_idle", {host_if.busy, host_if.tx_ready}, 2'b01);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
